mem_copy_engine: RTL
====================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter: WIDTH, default 8, memory address width in bits; the memory holds 2**WIDTH 32-bit words.
REQ-002 CLK  input  1  the single clock; all state changes on its rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 START  input  1  command strobe; sampled only in IDLE.
REQ-005 MODE  input  1  0 = copy (memory to memory), 1 = fill (constant to memory); latched on START.
REQ-006 SRC  input  WIDTH  copy source start address; latched on START.
REQ-007 DST  input  WIDTH  destination start address; latched on START.
REQ-008 LEN  input  WIDTH  word count; 0 = no transfer; latched on START.
REQ-009 FILL_DATA  input  32  fill value; latched on START.
REQ-010 BUSY  output  1  high in READ and WRITE states.
REQ-011 DONE  output  1  one-cycle completion pulse.
REQ-012 MEM_ADDR  output  WIDTH  memory word address.
REQ-013 MEM_DIN  output  32  write data to memory.
REQ-014 MEM_RW  output  1  1 = write, 0 = read.
REQ-015 MEM_VALID  output  1  memory access enable.
REQ-016 MEM_DOUT  input  32  memory read data; registered by the memory, valid in the cycle after a read access.

Function
REQ-017 FSM states SHALL be IDLE, READ, WRITE and DONE; MEM_*, BUSY and DONE SHALL be pure decodes of state and internal registers.
REQ-018 IDLE: on a cycle with START=1, the block SHALL latch MODE/SRC/DST/LEN/FILL_DATA, load src_ptr=SRC, dst_ptr=DST and remaining=LEN, then go to DONE if LEN=0, READ if MODE=0, or WRITE if MODE=1.
REQ-019 READ: the block SHALL drive MEM_VALID=1, MEM_RW=0, MEM_ADDR=src_ptr, MEM_DIN=0; next state SHALL be WRITE; src_ptr SHALL increment by 1.
REQ-020 WRITE: the block SHALL drive MEM_VALID=1, MEM_RW=1, MEM_ADDR=dst_ptr, and MEM_DIN = MEM_DOUT (copy) or the latched FILL_DATA (fill).
REQ-021 WRITE exit: dst_ptr SHALL increment, remaining SHALL decrement, and the next state SHALL be DONE if remaining was 1, otherwise READ (copy) or WRITE (fill).
REQ-022 DONE: DONE=1 and BUSY=0 for exactly one cycle, with MEM_VALID=0; next state SHALL be IDLE.
REQ-023 IDLE and DONE: MEM_VALID=0, MEM_RW=0, MEM_ADDR=0, MEM_DIN=0, and BUSY=0.
REQ-024 Latency: a copy of N>0 words SHALL take 2N cycles in READ/WRITE and a fill N cycles in WRITE; DONE SHALL be high in the cycle after the last write.
REQ-025 START in READ, WRITE or DONE SHALL be ignored, and SRC/DST/LEN/MODE/FILL_DATA changes SHALL not affect a transfer in progress.
REQ-026 Pointers SHALL wrap modulo 2**WIDTH (address 2**WIDTH-1 followed by 0).
REQ-027 A copy SHALL proceed in ascending address order with no overlap detection: with DST=SRC+1, the first source word SHALL replicate through the range.
REQ-028 LEN=0 SHALL issue no memory access and produce DONE in the cycle after START.

Reset
REQ-029 RESET=1 SHALL immediately force IDLE, clear src_ptr, dst_ptr, remaining and all latched command registers to 0, and drive BUSY=0, DONE=0, MEM_VALID=0, MEM_RW=0, MEM_ADDR=0, MEM_DIN=0.
REQ-030 RESET mid-transfer SHALL abort with no further memory access; words already written SHALL remain, and no DONE SHALL be produced.

Verification
REQ-031 Copy: mem[0x10..0x12]={A,B,C}; START with MODE=0, SRC=0x10, DST=0x40, LEN=3 -> six alternating read/write cycles, mem[0x40..0x42]={A,B,C}, and DONE pulses once in cycle 7 after START.
REQ-032 Fill: MODE=1, DST=0xFE, LEN=4, FILL_DATA=0xDEADBEEF -> writes to 0xFE, 0xFF, 0x00, 0x01 (wrap), 4 WRITE cycles, then DONE.
REQ-033 LEN=0 -> MEM_VALID stays 0, and DONE=1 in the next cycle.
REQ-034 START pulsed while BUSY with different SRC/DST -> ignored; the original transfer completes unchanged.
REQ-035 RESET asserted after the 2nd write of a LEN=5 copy -> all outputs 0 immediately, only 2 destination words modified, and no DONE.
REQ-036 Overlap: mem[0x20]=X, SRC=0x20, DST=0x21, LEN=3 -> mem[0x21..0x23]=X.

Source files
------------

// File: rtl/mem_copy_engine.sv
// Purpose: single-channel memory copy/fill engine driving a synchronous single-port memory.
// Latency: copy of N words = 2N cycles (read/write alternating), fill = N cycles, DONE one cycle after the last write.
// Backpressure: none; the memory is assumed to accept one access per cycle and START is ignored while a command runs.
//
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   start, mode, src, dst,
//   len, fill_data             command strobe and operands (sampled only in IDLE)
//   busy, done                 status: busy during READ/WRITE, done pulses for one cycle
//   mem_addr, mem_din, mem_rw,
//   mem_valid, mem_dout        memory port; mem_dout is registered by the memory (valid the cycle after a read)
module mem_copy_engine #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] dst,
    input  logic [WIDTH-1:0] len,
    input  logic [31:0]      fill_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] mem_addr,
    output logic [31:0]      mem_din,
    output logic             mem_rw,
    output logic             mem_valid,
    input  logic [31:0]      mem_dout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    // The source/destination/length operands live on in the working
    // pointers; only mode and fill value need a separate latched copy.
    logic             mode_q;
    logic [31:0]      fill_q;
    logic [WIDTH-1:0] src_ptr;
    logic [WIDTH-1:0] dst_ptr;
    logic [WIDTH-1:0] remaining;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command latch and working pointers. Pointer arithmetic is plain
    // WIDTH-bit, so addresses wrap from 2**WIDTH-1 to 0 by construction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q    <= 1'b0;
            fill_q    <= '0;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q    <= mode;
                        fill_q    <= fill_data;
                        src_ptr   <= src;
                        dst_ptr   <= dst;
                        remaining <= len;
                    end
                end
                S_READ: begin
                    src_ptr <= src_ptr + WIDTH'(1);
                end
                S_WRITE: begin
                    dst_ptr   <= dst_ptr + WIDTH'(1);
                    remaining <= remaining - WIDTH'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        mem_valid = 1'b0;
        mem_rw    = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_nxt = S_DONE;
                    end else if (mode) begin
                        state_nxt = S_WRITE;
                    end else begin
                        state_nxt = S_READ;
                    end
                end
            end
            S_READ: begin
                busy      = 1'b1;
                mem_valid = 1'b1;
                mem_addr  = src_ptr;
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                busy      = 1'b1;
                mem_valid = 1'b1;
                mem_rw    = 1'b1;
                mem_addr  = dst_ptr;
                // Copy forwards the word read in the previous cycle straight
                // from the memory's output register.
                mem_din   = mode_q ? fill_q : mem_dout;
                if (remaining == WIDTH'(1)) begin
                    state_nxt = S_DONE;
                end else if (mode_q) begin
                    state_nxt = S_WRITE;
                end else begin
                    state_nxt = S_READ;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
